// File: rtl/io_bridge_if.sv
// Signal bundle between the processor/host side and io_bridge.
// The bridge takes the slave view; whoever drives the strobes and host handshakes takes the master view.
interface io_bridge_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] ioOut;
    logic             io_wr;
    logic             io_rd;
    logic [WIDTH-1:0] ioIn;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    logic [CW-1:0]    in_count;
    logic [CW-1:0]    out_count;
    logic             overflow;
    logic             underflow;

    modport slave (
        input  ioOut, io_wr, io_rd,
        input  in_data, in_valid, out_ready,
        output ioIn, in_ready, out_data, out_valid,
        output in_count, out_count, overflow, underflow
    );

    modport master (
        output ioOut, io_wr, io_rd,
        output in_data, in_valid, out_ready,
        input  ioIn, in_ready, out_data, out_valid,
        input  in_count, out_count, overflow, underflow
    );
endinterface

// File: rtl/io_bridge.sv
// Host-side bridge for the processor's 16-bit I/O port.
// It holds one FIFO toward the processor and one FIFO from it, plus sticky error flags.
module io_bridge_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer MSB tells a full queue apart from an empty one.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

    // Full and empty are registered status, so a pop never frees room for a push in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset && w_do_push) begin
            r_mem[r_wr_ptr[PW-2:0]] <= i_data;
        end
    end
endmodule

module io_bridge #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        Reset,
    io_bridge_if.slave  bus
);
    logic w_in_full;
    logic w_in_empty;
    logic w_out_full;
    logic w_out_empty;
    logic r_overflow;
    logic r_underflow;

    io_bridge_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk     (clk),
        .Reset   (Reset),
        .i_push  (bus.in_valid),
        .i_data  (bus.in_data),
        .i_pop   (bus.io_rd),
        .o_head  (bus.ioIn),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (bus.in_count)
    );

    io_bridge_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .Reset   (Reset),
        .i_push  (bus.io_wr),
        .i_data  (bus.ioOut),
        .i_pop   (bus.out_ready),
        .o_head  (bus.out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (bus.out_count)
    );

    assign bus.in_ready  = !w_in_full;
    assign bus.out_valid = !w_out_empty;

    // The processor strobes are never stalled, so misuse is only recorded.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.io_wr && w_out_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.io_rd && w_in_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule
